// File: rtl/dpram_arbiter.sv
// Two-requester round-robin arbiter for the dualport_rw RAM.
// Write and read ports are arbitrated independently; read data is routed back by tag.
module dpram_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_write_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_read_en,
  output logic [ADDR_WIDTH-1:0] ram_read_address,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  logic wr_ptr;
  logic rd_ptr;
  logic rsp_pend;
  logic rsp_id;

  logic wc0, wc1, rc0, rc1;
  logic wg0, wg1, rg0, rg1;

  assign wc0 = req0_valid & req0_we;
  assign wc1 = req1_valid & req1_we;
  assign rc0 = req0_valid & ~req0_we;
  assign rc1 = req1_valid & ~req1_we;

  // Grants are forced low while reset is held so nothing reaches the RAM.
  assign wg0 = ~rst & wc0 & (~wc1 | ~wr_ptr);
  assign wg1 = ~rst & wc1 & (~wc0 | wr_ptr);
  assign rg0 = ~rst & rc0 & (~rc1 | ~rd_ptr);
  assign rg1 = ~rst & rc1 & (~rc0 | rd_ptr);

  assign req0_ready = wg0 | rg0;
  assign req1_ready = wg1 | rg1;

  assign ram_write_en = wg0 | wg1;
  assign ram_read_en  = rg0 | rg1;

  always_comb begin
    ram_write_address = '0;
    ram_data_in       = '0;
    unique case (1'b1)
      wg0: begin
        ram_write_address = req0_addr;
        ram_data_in       = req0_wdata;
      end
      wg1: begin
        ram_write_address = req1_addr;
        ram_data_in       = req1_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    ram_read_address = '0;
    unique case (1'b1)
      rg0:     ram_read_address = req0_addr;
      rg1:     ram_read_address = req1_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      rsp_pend <= 1'b0;
      rsp_id   <= 1'b0;
    end else begin
      if (wg0 | wg1)
        wr_ptr <= wg0;
      if (rg0 | rg1) begin
        rd_ptr <= rg0;
        rsp_id <= rg1;
      end
      rsp_pend <= rg0 | rg1;
    end
  end

  assign rsp0_valid = rsp_pend & ~rsp_id;
  assign rsp1_valid = rsp_pend & rsp_id;
  assign rsp0_rdata = rsp0_valid ? ram_data_out : '0;
  assign rsp1_rdata = rsp1_valid ? ram_data_out : '0;

endmodule

// File: doc/dpram_arbiter.md
Name: dpram_arbiter

Overview:
- Two-requester arbiter in front of the team's dual-port RAM (dualport_rw): 1 write port, 1 read port, 1-cycle registered read.
- Each requester has a valid/ready command channel (read or write) and a response channel for read data.
- Write port and read port are arbitrated independently with round-robin fairness, so one write and one read can issue in the same cycle.
- Each read response is routed back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 2, RAM address width.
- DATA_WIDTH, 4, RAM data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_WIDTH  command address.
- req0_wdata  in  DATA_WIDTH  write data (ignored for reads).
- req0_ready  out  1  command accepted this cycle.
- rsp0_valid  out  1  read data valid for requester 0.
- rsp0_rdata  out  DATA_WIDTH  read data for requester 0.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1.
- ram_write_en  out  1  drives RAM write_en.
- ram_write_address  out  ADDR_WIDTH  drives RAM write_address.
- ram_data_in  out  DATA_WIDTH  drives RAM data_in.
- ram_read_en  out  1  drives RAM read_en.
- ram_read_address  out  ADDR_WIDTH  drives RAM read_address.
- ram_data_out  in  DATA_WIDTH  RAM data_out.

Behaviour:
- Handshake:
  - A command transfers on a rising edge where reqN_valid && reqN_ready.
  - A requester holds valid, we, addr and wdata stable until ready.
  - reqN_ready is combinational from the current valids and the priority pointers; it never depends on reqN_ready of the other requester.
- Write arbitration:
  - Candidates are requesters with valid && we.
  - If both are candidates, the requester named by wr_ptr wins.
  - On a grant, wr_ptr moves to the other requester.
  - With one candidate, that candidate wins and wr_ptr still moves to the other requester.
  - With no candidate, wr_ptr holds.
- Read arbitration: identical, using candidates valid && !we and pointer rd_ptr.
- RAM drive:
  - ram_write_en = write grant; address and data muxed from the winner.
  - ram_read_en = read grant; address muxed from the winner.
  - With no grant, enables are 0 and address/data are driven with 0.
- Concurrency:
  - A write from one requester and a read from the other are both granted in the same cycle.
  - One requester can have at most one command per cycle, so it never gets both grants.
- Response path:
  - A registered tag (rsp_pend, rsp_id) is captured at every edge where a read is granted.
  - rspN_valid = rsp_pend && rsp_id==N, asserted exactly the cycle after the grant edge, for one cycle.
  - rspN_rdata = ram_data_out when rspN_valid, else 0.
  - Read latency is 1 cycle; back-to-back reads give rsp_valid on consecutive cycles.
- Same-address collision:
  - A write and a read granted in the same cycle to the same address return the new write data.
  - The RAM's bypass provides this; the arbiter adds no extra logic for it.
- Reset (asynchronous):
  - wr_ptr=0, rd_ptr=0, rsp_pend=0, rsp_id=0.
  - Outputs during reset: all ready=0, all rsp_valid=0, all rsp_rdata=0, all ram_* outputs=0.
  - A read granted on the edge before reset asserts produces no response.
  - The first grant after reset release goes to requester 0 on a tie.
- No backpressure on responses: the requester must always accept rsp_valid.

Test Plan:
- Reset, then req0 reads addr 2 alone (RAM preload 0xA,0xB,0xC,0xD) -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_rdata=0xC; rsp1_valid=0.
- Both requesters hold a read (req0 addr 0, req1 addr 1) for 4 cycles -> grants alternate 0,1,0,1; responses 0xA,0xB,0xA,0xB, each on the correct rsp port one cycle after its grant.
- Both requesters hold a write (req0 addr3=0x5, req1 addr3=0x6) -> req0 granted first, then req1; a later read of addr3 returns 0x6.
- req0 writes addr1=0x9 while req1 reads addr1 in the same cycle -> both ready=1; next cycle rsp1_rdata=0x9.
- req1 read granted, then rst pulsed asynchronously mid-cycle before the next edge -> rsp1_valid stays 0, all ram_* outputs 0; after release, a tie goes to req0.
- Idle with no valids for 3 cycles, then a single req1 write -> ram_write_en pulses 1 cycle; pointers unchanged during idle.
